// File: rtl/multdiv_seq_if.sv
// Pipeline-side bundle of the mult/div sequencer.
//   req_valid/req_ready/req_op/req_a/req_b : one operation offered by the pipeline
//   resp_valid/resp_ready                  : response handshake back to the pipeline
//   resp_data/resp_exception/resp_timeout  : captured result and status
// The master modport is the pipeline; the slave modport is the sequencer.
interface multdiv_seq_if #(
   parameter int WIDTH = 32
) ();
   logic             req_valid;
   logic             req_ready;
   logic             req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             resp_exception;
   logic             resp_timeout;

   modport master (
      output req_valid, req_op, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_exception, resp_timeout
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_data, resp_exception, resp_timeout
   );
endinterface

// File: rtl/multdiv_seq.sv
// Sequencer sitting in front of the iterative multiplier/divider.
// Accepts one operation, latches its operands, fires a one-cycle start pulse to
// the selected unit, waits for the unit's ready (or a timeout), then holds the
// response until the pipeline takes it.
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous reset, active-low
//   pipe           pipeline request/response bundle (slave side)
//   unit_a/unit_b  latched operands to the unit, stable from START until IDLE
//   ctrl_MULT      one-cycle start pulse to the multiplier
//   ctrl_DIV       one-cycle start pulse to the divider
//   unit_result    result from the selected unit
//   unit_exception overflow / divide-by-zero flag from the unit
//   unit_rdy       unit result valid
//   busy           high in START, WAIT and DONE
module multdiv_seq #(
   parameter int WIDTH      = 32,
   parameter int MAX_CYCLES = 40
) (
   input  logic             clk,
   input  logic             reset_n,
   multdiv_seq_if.slave     pipe,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   output logic             ctrl_MULT,
   output logic             ctrl_DIV,
   input  logic [WIDTH-1:0] unit_result,
   input  logic             unit_exception,
   input  logic             unit_rdy,
   output logic             busy
);

   localparam int CNT_W = $clog2(MAX_CYCLES) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] a_reg, b_reg, data_reg;
   logic             op_reg, exc_reg, tmo_reg;

   // Timeout only counts when the unit has not answered in that same cycle.
   logic timeout_hit;
   assign timeout_hit = (cnt_reg == CNT_LAST) && !unit_rdy;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         op_reg    <= 1'b0;
         data_reg  <= '0;
         exc_reg   <= 1'b0;
         tmo_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (pipe.req_valid) begin
                  a_reg  <= pipe.req_a;
                  b_reg  <= pipe.req_b;
                  op_reg <= pipe.req_op;
               end
            end
            START: cnt_reg <= '0;
            WAIT: begin
               if (cnt_reg != CNT_SAT)
                  cnt_reg <= cnt_reg + 1'b1;
               if (unit_rdy) begin
                  data_reg <= unit_result;
                  exc_reg  <= unit_exception;
                  tmo_reg  <= 1'b0;
               end else if (timeout_hit) begin
                  data_reg <= '0;
                  exc_reg  <= 1'b1;
                  tmo_reg  <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next     = state_reg;
      pipe.req_ready = 1'b0;
      ctrl_MULT      = 1'b0;
      ctrl_DIV       = 1'b0;
      busy           = 1'b1;
      case (state_reg)
         IDLE: begin
            pipe.req_ready = 1'b1;
            busy           = 1'b0;
            if (pipe.req_valid)
               state_next = START;
         end
         START: begin
            // A unit_rdy seen here belongs to the previous operation.
            ctrl_MULT  = !op_reg;
            ctrl_DIV   = op_reg;
            state_next = WAIT;
         end
         WAIT: begin
            if (unit_rdy || timeout_hit)
               state_next = DONE;
         end
         DONE: begin
            if (pipe.resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign pipe.resp_valid     = (state_reg == DONE);
   assign pipe.resp_data      = data_reg;
   assign pipe.resp_exception = exc_reg;
   assign pipe.resp_timeout   = tmo_reg;
   assign unit_a              = a_reg;
   assign unit_b              = b_reg;

endmodule
